// File: rtl/sens_buf_pkg.sv
// Shared constants, state encoding and address packing for the ToF frame
// buffer. The surface/plane read FSM imports this package too.
package sens_buf_pkg;
   localparam int ADDR_W    = 9;
   localparam int ZONES     = 64;
   localparam int N_SENS    = 8;
   localparam int PLANE_ROW = 3;

   typedef enum logic [1:0] {IDLE, FRAME, DRAIN, FULL} state_t;

   // Buffer address of one zone: sensor in the top bits, then row, then column.
   function automatic logic [ADDR_W-1:0] pack_addr(input logic [2:0] sens,
                                                   input logic [PLANE_ROW-1:0] row,
                                                   input logic [2:0] col);
      return {sens, row, col};
   endfunction
endpackage

// File: rtl/sens_frame_writer_if.sv
// Sample stream from the sensor capture logic into the frame writer.
interface sens_frame_writer_if #(parameter int DATA_W = 16);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_sens;
   logic [DATA_W-1:0] in_data;
   logic              in_last;

   modport master (output in_valid, in_sens, in_data, in_last, input in_ready);
   modport slave  (input in_valid, in_sens, in_data, in_last, output in_ready);
endinterface

// File: rtl/sens_buf_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module sens_buf_ram #(
   parameter int DATA_W = 16,
   parameter int AW     = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [0:(1<<AW)-1];

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   // Registered read port, always enabled
   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/sens_frame_writer.sv
// Producer side of the ToF frame buffer: writes 8x8 zone frames per sensor
// into the buffer and raises drdy when every required sensor has delivered
// a complete frame. Optional double buffering: define SENS_FRAME_PINGPONG_EN.
module sens_frame_writer
   import sens_buf_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter logic [N_SENS-1:0] SENS_MASK = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sens_frame_writer_if.slave   s_in,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 drdy,
   input  logic                 rd_done,
   output logic                 frame_err,
   output logic [N_SENS-1:0]    sens_done
);
`ifdef SENS_FRAME_PINGPONG_EN
   localparam int RAM_AW = ADDR_W + 1;
   logic wr_bank;
   logic rd_bank;
`else
   localparam int RAM_AW = ADDR_W;
`endif

   state_t            state;
   logic [5:0]        zone_cnt;
   logic [2:0]        cur_sens;
   logic              ready;

   logic              beat;
   logic              we;
   logic [2:0]        wr_sens;
   logic [ADDR_W-1:0] wr_addr;
   logic [N_SENS-1:0] done_set;
   logic              set_full;
   logic [RAM_AW-1:0] ram_wr_addr;
   logic [RAM_AW-1:0] ram_rd_addr;

   assign s_in.in_ready = ready;
   assign beat     = s_in.in_valid && ready;
   // The sensor index is only taken from the bus on the first beat of a frame.
   assign wr_sens  = (state == IDLE) ? s_in.in_sens : cur_sens;
   assign we       = beat && ((state == IDLE) || (state == FRAME));
   assign wr_addr  = pack_addr(wr_sens, zone_cnt[5:3], zone_cnt[2:0]);
   assign done_set = sens_done | (N_SENS'(1) << cur_sens);
   assign set_full = ((done_set & SENS_MASK) == SENS_MASK);

`ifdef SENS_FRAME_PINGPONG_EN
   assign ram_wr_addr = {wr_bank, wr_addr};
   assign ram_rd_addr = {rd_bank, rd_addr};
`else
   assign ram_wr_addr = wr_addr;
   assign ram_rd_addr = rd_addr;
`endif

   sens_buf_ram #(.DATA_W(DATA_W), .AW(RAM_AW)) u_ram (
      .clk     (clk),
      .we      (we),
      .wr_addr (ram_wr_addr),
      .wr_data (s_in.in_data),
      .rd_addr (ram_rd_addr),
      .rd_data (rd_data)
   );

   // Frame assembly FSM with registered handshake and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         zone_cnt  <= '0;
         cur_sens  <= '0;
         ready     <= 1'b0;
         drdy      <= 1'b0;
         frame_err <= 1'b0;
         sens_done <= '0;
`ifdef SENS_FRAME_PINGPONG_EN
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
`ifdef SENS_FRAME_PINGPONG_EN
         // Reader released its bank; the swap paths below re-assert drdy
         // when the other bank is already complete.
         if (rd_done) drdy <= 1'b0;
`endif
         case (state)
            IDLE: begin
               ready <= 1'b1;
               if (beat) begin
                  cur_sens <= s_in.in_sens;
                  if (s_in.in_last) begin
                     frame_err <= 1'b1;
                  end else begin
                     zone_cnt <= 6'd1;
                     state    <= FRAME;
                  end
               end
            end
            FRAME: begin
               if (beat) begin
                  if (s_in.in_last) begin
                     zone_cnt <= '0;
                     state    <= IDLE;
                     if (zone_cnt == 6'(ZONES - 1)) begin
                        sens_done <= done_set;
                        if (set_full) begin
`ifdef SENS_FRAME_PINGPONG_EN
                           if (!drdy || rd_done) begin
                              rd_bank   <= wr_bank;
                              wr_bank   <= ~wr_bank;
                              drdy      <= 1'b1;
                              sens_done <= '0;
                           end else begin
                              state <= FULL;
                              ready <= 1'b0;
                           end
`else
                           state <= FULL;
                           ready <= 1'b0;
                           drdy  <= 1'b1;
`endif
                        end
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else if (zone_cnt == 6'(ZONES - 1)) begin
                     frame_err <= 1'b1;
                     zone_cnt  <= '0;
                     state     <= DRAIN;
                  end else begin
                     zone_cnt <= zone_cnt + 6'd1;
                  end
               end
            end
            DRAIN: begin
               if (beat && s_in.in_last) state <= IDLE;
            end
            FULL: begin
               if (rd_done) begin
                  sens_done <= '0;
                  ready     <= 1'b1;
                  state     <= IDLE;
`ifdef SENS_FRAME_PINGPONG_EN
                  rd_bank   <= wr_bank;
                  wr_bank   <= ~wr_bank;
                  drdy      <= 1'b1;
`else
                  drdy      <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/sens_frame_writer.md
Name: sens_frame_writer

Overview:
- Producer side of the ToF sensor frame buffer.
- Accepts a valid/ready stream of per-zone distance samples, one 8x8 frame per sensor, and writes each sample into a 512-entry buffer at address {sens, row, col}.
- Asserts drdy once every required sensor has delivered a complete frame, and holds it until the read-side FSM signals rd_done.
- Sits between the sensor I2C/SPI capture logic and the surface/plane read FSM, which drives rd_addr.

Parameters:
- DATA_W, 16, width of one zone sample.
- SENS_MASK, 8'hFF, sensors that must complete a frame before drdy; bit i = sensor i.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  writer can accept a sample
- in_sens  in  3  sensor index; sampled on the first beat of a frame only
- in_data  in  DATA_W  zone sample
- in_last  in  1  marks the final (64th) beat of a frame
- rd_addr  in  9  read address {sens[8:6], row[5:3], col[2:0]}
- rd_data  out  DATA_W  read data, 1-cycle latency
- drdy  out  1  complete frame set available (level)
- rd_done  in  1  one-cycle pulse: reader finished with the current set
- frame_err  out  1  one-cycle pulse on a malformed frame
- sens_done  out  8  per-sensor completed-frame mask for the set being filled

Behaviour:
- Reset values: in_ready=0, drdy=0, frame_err=0, sens_done=0, state=IDLE, zone_cnt=0. RAM contents are not reset. in_ready rises on the first cycle after rst_n deasserts.
- Beat acceptance: a beat is taken when in_valid && in_ready.
  - Write address = {cur_sens, zone_cnt[5:3], zone_cnt[2:0]}, row-major.
  - RAM write occurs in the same cycle as the beat.
- States:
  - IDLE: in_ready=1. An accepted beat latches cur_sens=in_sens, writes zone 0, zone_cnt=1, and moves to FRAME. A single-beat frame with in_last=1 is a short frame: frame_err pulses and the state stays IDLE.
  - FRAME: in_ready=1. Each beat writes, then zone_cnt++.
    - in_last with zone_cnt==63: set sens_done[cur_sens]. If (sens_done|bit) & SENS_MASK == SENS_MASK, go to FULL; else go to IDLE.
    - in_last with zone_cnt<63: short frame. frame_err pulses, sens_done is unchanged, go to IDLE.
    - zone_cnt==63 without in_last: long frame. frame_err pulses, go to DRAIN.
  - DRAIN: in_ready=1. Beats are dropped with no RAM write. On an accepted in_last, go to IDLE. sens_done[cur_sens] is not set.
  - FULL: drdy=1, in_ready=0. On rd_done: sens_done=0, drdy=0, go to IDLE next cycle.
- Repeated frame for a sensor already in sens_done: the RAM region is overwritten and the bit stays set (no double count).
- A frame for a sensor outside SENS_MASK is written and its sens_done bit is set, but it does not gate drdy.
- rd_done outside FULL is ignored.
- Reads: rd_data = RAM[rd_addr] registered, always enabled. Read-during-write to the same address returns old data.
- rst_n assertion mid-frame aborts the frame immediately (asynchronously); the partial frame is not counted.

Optional Feature:
- Macro: SENS_FRAME_PINGPONG_EN.
- With the macro: two 512-entry banks, with wr_bank and rd_bank bits.
  - On set complete, if no set is pending for the reader: rd_bank<=wr_bank, wr_bank toggles, drdy=1, return to IDLE (in_ready stays 1).
  - If a set is pending: enter FULL with in_ready=0.
  - On rd_done with no other bank complete: drdy=0.
  - On rd_done while in FULL: rd_bank<=wr_bank, wr_bank toggles, drdy stays 1, go to IDLE.
  - Set complete and rd_done in the same cycle: the swap happens and drdy stays 1.
  - The reader always sees rd_bank. rd_addr width is unchanged.
- Without the macro: single bank, behaviour exactly as above.

Decomposition:
- Package sens_buf_pkg: ADDR_W=9, ZONES=64, N_SENS=8, PLANE_ROW=3, state enum {IDLE, FRAME, DRAIN, FULL}, and an address-pack function {sens,row,col}. The read FSM shares this package.
- One sub-module: sens_buf_ram, a simple dual-port RAM (1 write port, 1 registered read port, DATA_W x 512, or x1024 with ping-pong).

Test Plan:
- 8 complete frames, sensors 0..7, data=(sens<<8)|zone → drdy rises the cycle after beat 512; rd_addr=9'h1C5 gives rd_data=16'h0705 one cycle later.
- Sensor 3 frame with in_last on beat 40 → frame_err pulse, sens_done[3]=0, drdy stays 0 after the other 7 sensors complete.
- Sensor 2 sends 70 beats with in_last on beat 70 → frame_err at beat 64, beats 65-70 not written, in_ready=1 throughout, state returns to IDLE.
- Full set, then hold rd_done=0 → in_ready=0 and in_valid is ignored; rd_done pulse → drdy=0 and in_ready=1 next cycle.
- SENS_MASK=8'h0F, frames for sensors 0-3 only → drdy=1. Also: reset asserted mid-frame of sensor 1 → sens_done=0, drdy=0, in_ready=1 after release.
- Ping-pong build: second set completes while the first is unread → FULL with in_ready=0; rd_done → swap, drdy stays 1, reads return second-set data.
